// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for alu_pipe_unit and its multiplier.
//   - OP_* : 4-bit opcode encodings
//   - state_e : control FSM states (ST_IDLE, ST_MUL)
//   - signed_ovf : signed-overflow detect for add/sub from operand/result sign bits
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_NOTA  = 4'b0011;
  localparam logic [3:0] OP_SHLA  = 4'b0100;
  localparam logic [3:0] OP_SHRL  = 4'b0101;
  localparam logic [3:0] OP_SHRA  = 4'b0110;
  localparam logic [3:0] OP_PASS0 = 4'b0111;
  localparam logic [3:0] OP_PASS1 = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_NOTB  = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Subtraction is addition of the inverted B operand, so B's sign is flipped
  // before the usual "same input signs, different result sign" test.
  function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-cycle shift-add multiplier on operand magnitudes with a
// final sign correction; returns the low WIDTH bits of the signed product.
// Built only when ALU_PIPE_MUL_EN is defined.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (aborts a run)
//   start            load operands a/b and begin (ignored bits of state reset)
//   a, b             signed operands
//   busy             a multiplication is in progress (includes the done cycle)
//   done             result valid this cycle; busy clears on the next edge
//   result           low WIDTH bits of a*b, valid while done
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    busy_d   = busy_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    done     = busy_q && (cnt_q == CNT_W'(WIDTH));
    if (start) begin
      busy_d   = 1'b1;
      neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
      mcand_d  = a[WIDTH-1] ? ('0 - a) : a;
      mplier_d = b[WIDTH-1] ? ('0 - b) : b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (done) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      // Only the low WIDTH bits of the product are kept, so the multiplicand
      // may shift out of range without affecting the result.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy   = busy_q;
  assign result = neg_q ? ('0 - acc_q) : acc_q;

endmodule
`endif

// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: registered ALU with valid/ready handshake on both sides.
// Single-cycle ops have latency 1; with ALU_PIPE_MUL_EN defined, opcode 1100
// is a WIDTH+1 cycle signed multiply (otherwise it behaves as 1101-1111).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake
//   operation, inp1, inp2      opcode and operands (inp2 low bits = shift amount)
//   out_valid/out_ready        result handshake; out and flags hold while stalled
//   out                        result
//   carryFlag                  add carry-out / sub no-borrow, held by other ops
//   zeroFlag, signFlag         result == 0, result MSB (0 for opcodes 1101-1111)
//   overflowFlag               signed overflow of add/sub, cleared by other ops
module alu_pipe_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             signFlag,
  output logic             overflowFlag
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   res;
  logic               res_carry, res_ovf, res_known, res_zero, res_sign;

`ifdef ALU_PIPE_MUL_EN
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_result;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (inp1),
    .b      (inp2),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );

  assign in_ready = (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
`else
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
`endif

  assign accept = in_valid && in_ready;

  // Single-cycle operation mux.
  always_comb begin
    sum       = {1'b0, inp1} + {1'b0, inp2};
    diff      = inp1 - inp2;
    shamt     = inp2[SHAMT_W-1:0];
    res       = '0;
    res_carry = carry_q;
    res_ovf   = 1'b0;
    res_known = 1'b1;
    case (operation)
      OP_ADD: begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = signed_ovf(1'b0, inp1[WIDTH-1], inp2[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        res       = diff;
        res_carry = (inp1 >= inp2);
        res_ovf   = signed_ovf(1'b1, inp1[WIDTH-1], inp2[WIDTH-1], diff[WIDTH-1]);
      end
      OP_AND:            res = inp1 & inp2;
      OP_OR:             res = inp1 | inp2;
      OP_XOR:            res = inp1 ^ inp2;
      OP_NOTA:           res = ~inp1;
      OP_NOTB:           res = ~inp2;
      OP_SHLA:           res = inp1 << shamt;
      OP_SHRL:           res = inp1 >> shamt;
      OP_SHRA:           res = $unsigned($signed(inp1) >>> shamt);
      OP_PASS0, OP_PASS1: res = inp1;
      default:           res_known = 1'b0;
    endcase
    res_zero = res_known && (res == '0);
    res_sign = res_known && res[WIDTH-1];
  end

  // Control FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
`ifdef ALU_PIPE_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (operation == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else
`endif
          begin
            out_d       = res;
            carry_d     = res_carry;
            zero_d      = res_zero;
            sign_d      = res_sign;
            ovf_d       = res_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
`ifdef ALU_PIPE_MUL_EN
      // The output stage is always empty here: a mul is only accepted when
      // the previous result drains, and nothing else completes meanwhile.
      ST_MUL: begin
        if (mul_done) begin
          out_d       = mul_result;
          zero_d      = (mul_result == '0);
          sign_d      = mul_result[WIDTH-1];
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out          = out_q;
  assign carryFlag    = carry_q;
  assign zeroFlag     = zero_q;
  assign signFlag     = sign_q;
  assign overflowFlag = ovf_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Testbench for alu_pipe_unit (WIDTH=32). Honors ALU_PIPE_MUL_EN.
module tb_alu_pipe_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  operation;
  logic [31:0] inp1, inp2;
  logic        out_valid, out_ready;
  logic [31:0] out;
  logic        carryFlag, zeroFlag, signFlag, overflowFlag;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] o;
    logic c, z, s, v;
  } res_t;

  alu_pipe_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operation    (operation),
    .inp1         (inp1),
    .inp2         (inp2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out          (out),
    .carryFlag    (carryFlag),
    .zeroFlag     (zeroFlag),
    .signFlag     (signFlag),
    .overflowFlag (overflowFlag)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: 64-bit integer arithmetic, range checks for overflow.
  function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    res_t    r;
    longint  sa, sb, s, ua, ub, u;
    int      sh;
    bit      known;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    r.o = 32'h0; r.c = cin; r.v = 1'b0; known = 1'b1;
    case (op)
      4'd0: begin
        u = ua + ub; r.o = u[31:0]; r.c = (u >= 64'sd4294967296);
        s = sa + sb; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd10: begin
        u = ua - ub; r.o = u[31:0]; r.c = (ua >= ub);
        s = sa - sb; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1:  r.o = a & b;
      4'd2:  r.o = a ^ b;
      4'd3:  r.o = ~a;
      4'd4:  r.o = a << sh;
      4'd5:  r.o = a >> sh;
      4'd6:  begin s = sa >>> sh; r.o = s[31:0]; end
      4'd7, 4'd8: r.o = a;
      4'd9:  r.o = a | b;
      4'd11: r.o = ~b;
`ifdef ALU_PIPE_MUL_EN
      4'd12: begin s = sa * sb; r.o = s[31:0]; end
`endif
      default: known = 1'b0;
    endcase
    if (known) begin
      r.z = (r.o == 32'h0);
      r.s = r.o[31];
    end else begin
      r.o = 32'h0; r.z = 1'b0; r.s = 1'b0; r.v = 1'b0;
    end
    return r;
  endfunction

  // Present a request and hold it until accepted; returns on the falling edge
  // after the accepting rising edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    operation = op; inp1 = a; inp2 = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL send_accept: op=%h not accepted within 100 cycles", op);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; operation = 4'h0; inp1 = '0; inp2 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag} !== 37'h0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b out=%h c%b z%b s%b v%b, want all 0",
               out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] o;
    logic        c, z, s, v;
  } vec_t;

  task automatic test_directed();
    vec_t tv[$];
    tv.push_back('{4'd0,  32'h7FFFFFFF, 32'h1,   32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1});
    tv.push_back('{4'd10, 32'h5,        32'h5,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{4'd1,  32'hF0,       32'h0F,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{4'd13, 32'hFF,       32'hFF,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{4'd6,  32'h80000000, 32'd36,  32'hF8000000, 1'b1, 1'b0, 1'b1, 1'b0});
    tv.push_back('{4'd5,  32'h80000000, 32'd36,  32'h08000000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{4'd4,  32'h1,        32'd31,  32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0});
    tv.push_back('{4'd0,  32'hFFFFFFFF, 32'h1,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{4'd10, 32'h80000000, 32'h1,   32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1});
    tv.push_back('{4'd10, 32'h1,        32'h2,   32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0});
    tv.push_back('{4'd11, 32'h1234,     32'h0,   32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0});
    tv.push_back('{4'd7,  32'h1234,     32'hFF,  32'h1234,     1'b0, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b1;
    foreach (tv[i]) begin
      send(tv[i].op, tv[i].a, tv[i].b);
      checks++;
      if ({out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag} !==
          {1'b1, tv[i].o, tv[i].c, tv[i].z, tv[i].s, tv[i].v}) begin
        errors++;
        $display("FAIL directed[%0d] op=%h: got valid=%b out=%h c%b z%b s%b v%b, want valid=1 out=%h c%b z%b s%b v%b",
                 i, tv[i].op, out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag,
                 tv[i].o, tv[i].c, tv[i].z, tv[i].s, tv[i].v);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send(4'd0, 32'd3, 32'd4);
    operation = 4'd2; inp1 = 32'hFF; inp2 = 32'h0F; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({out_valid, in_ready, out, carryFlag, zeroFlag, signFlag, overflowFlag} !==
          {1'b1, 1'b0, 32'd7, 4'b0000}) begin
        errors++;
        $display("FAIL stall[%0d]: got valid=%b in_ready=%b out=%h flags=%b%b%b%b, want valid=1 in_ready=0 out=7 flags=0000",
                 k, out_valid, in_ready, out, carryFlag, zeroFlag, signFlag, overflowFlag);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag} !== {1'b1, 32'hF0, 4'b0000}) begin
      errors++;
      $display("FAIL release_reload: got valid=%b out=%h flags=%b%b%b%b, want valid=1 out=f0 flags=0000",
               out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag);
    end
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    int cyc;
    bit busy_ok;
    logic [31:0] pa[2], pb[2], po[2];
    pa[0] = 32'd7;     pb[0] = 32'hFFFFFFFD; po[0] = 32'hFFFFFFEB;
    pa[1] = 32'h10000; pb[1] = 32'h10000;    po[1] = 32'h0;
    out_ready = 1'b1;
    send(4'd10, 32'd5, 32'd5);  // carry := 1 so the hold through mul is visible
    for (int t = 0; t < 2; t++) begin
      send(4'd12, pa[t], pb[t]);
      cyc = 0; busy_ok = 1'b1;
      while (!out_valid && cyc < 100) begin
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != 33 || !busy_ok) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got %0d cycles (in_ready low=%b), want 33 (1)", t, cyc, busy_ok);
      end
      checks++;
      if ({out, carryFlag, zeroFlag, signFlag, overflowFlag} !==
          {po[t], 1'b1, po[t] == 32'h0, po[t][31], 1'b0}) begin
        errors++;
        $display("FAIL mul_result[%0d]: got out=%h c%b z%b s%b v%b, want out=%h c1 z%b s%b v0",
                 t, out, carryFlag, zeroFlag, signFlag, overflowFlag, po[t], po[t] == 32'h0, po[t][31]);
      end
    end
  endtask
`endif

  task automatic test_reset_abort();
    bit saw;
    out_ready = 1'b1;
    @(negedge clk);
`ifdef ALU_PIPE_MUL_EN
    send(4'd12, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
`else
    out_ready = 1'b0;
    send(4'd0, 32'h7FFFFFFF, 32'h1);
`endif
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag} !== 37'h0) begin
      errors++;
      $display("FAIL abort_clear: got valid=%b out=%h flags=%b%b%b%b, want all 0",
               out_valid, out, carryFlag, zeroFlag, signFlag, overflowFlag);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_ready: got %b want 1", in_ready);
    end
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL abort_stale: got out_valid seen=%b want 0", saw);
    end
  endtask

  task automatic test_random();
    res_t        q[$];
    res_t        e;
    logic        mcarry;
    logic [31:0] special[4];
    int          cyc;
    special[0] = 32'h0; special[1] = 32'h7FFFFFFF; special[2] = 32'h80000000; special[3] = 32'hFFFFFFFF;
    apply_reset();
    mcarry = 1'b0;
    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      operation = 4'($urandom_range(0, 15));
      if (operation == 4'd12 && $urandom_range(0, 3) != 0) operation = 4'd10;
      inp1 = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : 32'($urandom);
      inp2 = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : 32'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got out=%h with no request outstanding, want none", out);
        end else begin
          e = q.pop_front();
          if ({out, carryFlag, zeroFlag, signFlag, overflowFlag} !== {e.o, e.c, e.z, e.s, e.v}) begin
            errors++;
            $display("FAIL rand_result: got out=%h c%b z%b s%b v%b, want out=%h c%b z%b s%b v%b",
                     out, carryFlag, zeroFlag, signFlag, overflowFlag, e.o, e.c, e.z, e.s, e.v);
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(operation, inp1, inp2, mcarry);
        mcarry = e.c;
        q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        checks++;
        if ({out, carryFlag, zeroFlag, signFlag, overflowFlag} !== {e.o, e.c, e.z, e.s, e.v}) begin
          errors++;
          $display("FAIL rand_drain: got out=%h c%b z%b s%b v%b, want out=%h c%b z%b s%b v%b",
                   out, carryFlag, zeroFlag, signFlag, overflowFlag, e.o, e.c, e.z, e.s, e.v);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_outstanding: got %0d results missing, want 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; inp1 = '0; inp2 = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
`endif
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
